// File: rtl/lsu_if.sv
// Bundles the three buses around the load/store unit: execute-side request,
// writeback-side response, and the strobe interface to dat_mem.
// slave modport: seen from the lsu. master modport: seen from the surroundings.
interface lsu_if;
    // request from execute
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct;
    logic [31:0] req_base;
    logic [11:0] req_imm;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    // response to writeback
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [4:0]  rsp_rd;
    logic        rsp_err;
    logic [1:0]  rsp_cause;
    // dat_mem port
    logic [31:0] mem_addr;
    logic [31:0] mem_wdat;
    logic [2:0]  mem_funct;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdat;

    modport slave (
        input  req_valid, req_we, req_funct, req_base, req_imm, req_wdata, req_rd,
        output req_ready,
        input  rsp_ready,
        output rsp_valid, rsp_rdata, rsp_rd, rsp_err, rsp_cause,
        output mem_addr, mem_wdat, mem_funct, mem_read, mem_write,
        input  mem_rdat
    );

    modport master (
        output req_valid, req_we, req_funct, req_base, req_imm, req_wdata, req_rd,
        input  req_ready,
        output rsp_ready,
        input  rsp_valid, rsp_rdata, rsp_rd, rsp_err, rsp_cause,
        input  mem_addr, mem_wdat, mem_funct, mem_read, mem_write,
        output mem_rdat
    );
endinterface

// File: rtl/lsu.sv
// Load/store unit: one request in flight, checks legality/alignment/range, drives dat_mem, returns result or fault.
// Latency: fault -> response after the accept edge; store one edge later; load two edges later (memory read is registered).
// Backpressure: response is held stable in RESP until rsp_ready; req_ready is high only in IDLE (and out of reset).
// Ports: clk, rst_n (async active-low) and bus (lsu_if.slave) carrying req_*, rsp_* and mem_* groups.
module lsu #(
    parameter int unsigned MEM_BYTES = 4096
) (
    input  logic   clk,
    input  logic   rst_n,
    lsu_if.slave   bus
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic        we_q;
    logic [2:0]  funct_q;
    logic [31:0] wdata_q;
    logic [31:0] ea_q;
    logic [4:0]  rd_q;
    logic        err_q;
    logic [1:0]  cause_q;
    logic [31:0] rdata_q, rdata_d;

    logic        accept;
    logic [31:0] ea_w;
    logic [2:0]  size_w;
    logic [32:0] end_w;
    logic        illegal_w, misalign_w, oor_w;
    logic [1:0]  cause_w;
    logic [31:0] byte_w, half_w;

    // req_ready is gated by rst_n so it reads 0 while reset is held even though
    // the state register already sits in IDLE.
    assign bus.req_ready = rst_n && (state_q == S_IDLE);
    assign accept        = bus.req_valid && bus.req_ready;

    // Legality checks on the incoming request, evaluated in the accept cycle.
    always_comb begin
        ea_w      = bus.req_base + {{20{bus.req_imm[11]}}, bus.req_imm};
        illegal_w = (bus.req_funct == 3'b011) || (bus.req_funct[2:1] == 2'b11)
                    || (bus.req_we && bus.req_funct[2]);
        case (bus.req_funct[1:0])
            2'b00:   size_w = 3'd1;
            2'b01:   size_w = 3'd2;
            default: size_w = 3'd4;
        endcase
        misalign_w = ((bus.req_funct[1:0] == 2'b01) && ea_w[0])
                     || ((bus.req_funct[1:0] == 2'b10) && (ea_w[1:0] != 2'b00));
        // 33-bit sum so an access that wraps past 2^32 still reads as too high
        end_w = {1'b0, ea_w} + {30'd0, size_w};
        oor_w = end_w > 33'(MEM_BYTES);
        if (illegal_w)       cause_w = 2'b11;
        else if (misalign_w) cause_w = 2'b01;
        else if (oor_w)      cause_w = 2'b10;
        else                 cause_w = 2'b00;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = (cause_w != 2'b00) ? S_RESP : S_ISSUE;
            S_ISSUE: state_d = we_q ? S_RESP : S_WAIT;
            S_WAIT:  state_d = S_RESP;
            S_RESP:  if (bus.rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Lane extraction from the aligned word returned by dat_mem.
    always_comb begin
        byte_w = bus.mem_rdat >> {ea_q[1:0], 3'b000};
        half_w = bus.mem_rdat >> {ea_q[1], 4'b0000};
        case (funct_q)
            3'b000:  rdata_d = {{24{byte_w[7]}}, byte_w[7:0]};
            3'b100:  rdata_d = {24'd0, byte_w[7:0]};
            3'b001:  rdata_d = {{16{half_w[15]}}, half_w[15:0]};
            3'b101:  rdata_d = {16'd0, half_w[15:0]};
            default: rdata_d = bus.mem_rdat;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            funct_q <= 3'd0;
            wdata_q <= 32'd0;
            ea_q    <= 32'd0;
            rd_q    <= 5'd0;
            err_q   <= 1'b0;
            cause_q <= 2'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q    <= bus.req_we;
                funct_q <= bus.req_funct;
                wdata_q <= bus.req_wdata;
                ea_q    <= ea_w;
                rd_q    <= bus.req_rd;
                err_q   <= (cause_w != 2'b00);
                cause_q <= cause_w;
                rdata_q <= 32'd0;    // stores and faults report zero data
            end else if (state_q == S_WAIT) begin
                rdata_q <= rdata_d;
            end
        end
    end

    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_rd    = rd_q;
    assign bus.rsp_err   = err_q;
    assign bus.rsp_cause = cause_q;

    // Strobes decode from state only; the async reset of state_q removes an
    // in-flight strobe before the next edge.
    always_comb begin
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_addr  = 32'd0;
        bus.mem_wdat  = 32'd0;
        bus.mem_funct = 3'd0;
        if (state_q == S_ISSUE) begin
            if (we_q) begin
                bus.mem_write = 1'b1;
                bus.mem_addr  = ea_q;
                bus.mem_wdat  = wdata_q;
                bus.mem_funct = funct_q;
            end else begin
                bus.mem_read  = 1'b1;
                bus.mem_addr  = {ea_q[31:2], 2'b00};
                bus.mem_funct = 3'b010;
            end
        end
    end

endmodule

// File: tb/tb_lsu.sv
module tb_lsu;

    logic clk;
    logic rst_n;
    lsu_if bus ();

    lsu #(.MEM_BYTES(4096)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- dat_mem model ----------------
    logic [7:0]  mem [0:4095];
    bit          init_done = 1'b0;
    logic [11:0] ma;
    assign ma = bus.mem_addr[11:0];

    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
            mem[12'h100] <= 8'h78; mem[12'h101] <= 8'h56;
            mem[12'h102] <= 8'h34; mem[12'h103] <= 8'h12;
            mem[12'h202] <= 8'hFF; mem[12'h203] <= 8'h80;
            init_done <= 1'b1;
        end else begin
            if (bus.mem_write) begin
                case (bus.mem_funct[1:0])
                    2'b00: mem[ma] <= bus.mem_wdat[7:0];
                    2'b01: begin
                        mem[ma]         <= bus.mem_wdat[7:0];
                        mem[ma + 12'd1] <= bus.mem_wdat[15:8];
                    end
                    default: begin
                        mem[ma]         <= bus.mem_wdat[7:0];
                        mem[ma + 12'd1] <= bus.mem_wdat[15:8];
                        mem[ma + 12'd2] <= bus.mem_wdat[23:16];
                        mem[ma + 12'd3] <= bus.mem_wdat[31:24];
                    end
                endcase
            end
            if (bus.mem_read)
                bus.mem_rdat <= {mem[ma + 12'd3], mem[ma + 12'd2], mem[ma + 12'd1], mem[ma]};
        end
    end

    // ---------------- strobe monitor ----------------
    int          rd_cnt = 0, wr_cnt = 0, both_cnt = 0;
    logic [31:0] last_addr, last_wdat;
    logic [2:0]  last_funct;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.mem_read && bus.mem_write) both_cnt++;
            if (bus.mem_read || bus.mem_write) begin
                last_addr  = bus.mem_addr;
                last_wdat  = bus.mem_wdat;
                last_funct = bus.mem_funct;
            end
            if (bus.mem_read)  rd_cnt++;
            if (bus.mem_write) wr_cnt++;
        end
    end

    // ---------------- checking helpers ----------------
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic chk_reset_outs(input string nm);
        chk({nm, " req_ready"}, 32'(bus.req_ready), 32'd0);
        chk({nm, " rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        chk({nm, " rsp_err"},   32'(bus.rsp_err),   32'd0);
        chk({nm, " rsp_cause"}, 32'(bus.rsp_cause), 32'd0);
        chk({nm, " rsp_rdata"}, bus.rsp_rdata,      32'd0);
        chk({nm, " rsp_rd"},    32'(bus.rsp_rd),    32'd0);
        chk({nm, " strobes"},   {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
        chk({nm, " mem_addr"},  bus.mem_addr,       32'd0);
        chk({nm, " mem_wdat"},  bus.mem_wdat,       32'd0);
        chk({nm, " mem_funct"}, 32'(bus.mem_funct), 32'd0);
    endtask

    typedef struct {
        string       name;
        logic        we;
        logic [2:0]  funct;
        logic [31:0] base;
        logic [11:0] imm;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_cause;
        int          exp_lat;    // edges from accept edge (inclusive) to rsp_valid
        logic [31:0] exp_maddr;
    } vec_t;

    function automatic vec_t mk(input string nm, input logic we, input logic [2:0] f,
                                input logic [31:0] b, input logic [11:0] im, input logic [31:0] wd,
                                input logic [31:0] er, input logic [1:0] ec, input int el,
                                input logic [31:0] emaddr);
        vec_t v;
        v.name = nm; v.we = we; v.funct = f; v.base = b; v.imm = im; v.wdata = wd;
        v.exp_rdata = er; v.exp_cause = ec; v.exp_lat = el; v.exp_maddr = emaddr;
        return v;
    endfunction

    task automatic drive_req(input logic we, input logic [2:0] f, input logic [31:0] b,
                             input logic [11:0] im, input logic [31:0] wd, input logic [4:0] rd);
        bus.req_we = we; bus.req_funct = f; bus.req_base = b;
        bus.req_imm = im; bus.req_wdata = wd; bus.req_rd = rd;
        bus.req_valid = 1'b1;
    endtask

    // Apply one request with rsp_ready held high and check everything about it.
    task automatic run_req(input vec_t v, input logic [4:0] rd);
        int lat, guard, r0, w0;
        guard = 0;
        while (!bus.req_ready && guard < 10) begin tick(); guard++; end
        chk({v.name, " ready before"}, 32'(bus.req_ready), 32'd1);
        r0 = rd_cnt; w0 = wr_cnt;
        drive_req(v.we, v.funct, v.base, v.imm, v.wdata, rd);
        lat = 0;
        do begin
            tick();
            lat++;
            bus.req_valid = 1'b0;
        end while (!bus.rsp_valid && lat < 10);
        chk({v.name, " latency"}, 32'(lat),             32'(v.exp_lat));
        chk({v.name, " err"},     32'(bus.rsp_err),      32'(v.exp_cause != 2'b00));
        chk({v.name, " cause"},   32'(bus.rsp_cause),    32'(v.exp_cause));
        chk({v.name, " rdata"},   bus.rsp_rdata,         v.exp_rdata);
        chk({v.name, " rd"},      32'(bus.rsp_rd),       32'(rd));
        chk({v.name, " reads"},   32'(rd_cnt - r0),      32'(v.exp_lat == 3));
        chk({v.name, " writes"},  32'(wr_cnt - w0),      32'(v.exp_lat == 2));
        if (v.exp_lat == 3) begin
            chk({v.name, " rd addr"},  last_addr,         v.exp_maddr);
            chk({v.name, " rd funct"}, 32'(last_funct),   32'd2);
        end
        if (v.exp_lat == 2) begin
            chk({v.name, " wr addr"},  last_addr,         v.exp_maddr);
            chk({v.name, " wr funct"}, 32'(last_funct),   32'(v.funct));
            chk({v.name, " wr data"},  last_wdat,         v.wdata);
        end
        tick();    // handshake edge
        chk({v.name, " rsp drop"}, 32'(bus.rsp_valid), 32'd0);
    endtask

    vec_t vt[$];

    initial begin
        logic [31:0] snap_rdata;
        logic [4:0]  snap_rd;
        int          r0, w0, guard;

        // LOAD=0/STORE=1, funct, base, imm, wdata, exp rdata, cause, latency, strobe addr
        vt.push_back(mk("LW 100",     0, 3'b010, 32'h100, 12'h000, 0, 32'h12345678, 2'b00, 3, 32'h100));
        vt.push_back(mk("LB 103",     0, 3'b000, 32'h100, 12'h003, 0, 32'h00000012, 2'b00, 3, 32'h100));
        vt.push_back(mk("LB 202",     0, 3'b000, 32'h200, 12'h002, 0, 32'hFFFFFFFF, 2'b00, 3, 32'h200));
        vt.push_back(mk("LH 202",     0, 3'b001, 32'h200, 12'h002, 0, 32'hFFFF80FF, 2'b00, 3, 32'h200));
        vt.push_back(mk("LHU 202",    0, 3'b101, 32'h200, 12'h002, 0, 32'h000080FF, 2'b00, 3, 32'h200));
        vt.push_back(mk("LBU 203",    0, 3'b100, 32'h200, 12'h003, 0, 32'h00000080, 2'b00, 3, 32'h200));
        vt.push_back(mk("LH 200",     0, 3'b001, 32'h200, 12'h000, 0, 32'h00000000, 2'b00, 3, 32'h200));
        vt.push_back(mk("LW neg imm", 0, 3'b010, 32'h104, 12'hFFC, 0, 32'h12345678, 2'b00, 3, 32'h100));
        vt.push_back(mk("SB 105",     1, 3'b000, 32'h100, 12'h005, 32'hAABBCCDD, 0, 2'b00, 2, 32'h105));
        vt.push_back(mk("LBU 105",    0, 3'b100, 32'h104, 12'h001, 0, 32'h000000DD, 2'b00, 3, 32'h104));
        vt.push_back(mk("SH 106",     1, 3'b001, 32'h106, 12'h000, 32'h1234BEEF, 0, 2'b00, 2, 32'h106));
        vt.push_back(mk("LW 104",     0, 3'b010, 32'h104, 12'h000, 0, 32'hBEEFDD00, 2'b00, 3, 32'h104));
        vt.push_back(mk("LW 102",     0, 3'b010, 32'h102, 12'h000, 0, 0, 2'b01, 1, 0));
        vt.push_back(mk("LH 107",     0, 3'b001, 32'h104, 12'h003, 0, 0, 2'b01, 1, 0));
        vt.push_back(mk("SH 201",     1, 3'b001, 32'h201, 12'h000, 32'h5555, 0, 2'b01, 1, 0));
        vt.push_back(mk("LW FFE",     0, 3'b010, 32'hFFE, 12'h000, 0, 0, 2'b01, 1, 0));
        vt.push_back(mk("LW 1000",    0, 3'b010, 32'h1000, 12'h000, 0, 0, 2'b10, 1, 0));
        vt.push_back(mk("LB FFF",     0, 3'b000, 32'hFFF, 12'h000, 0, 0, 2'b00, 3, 32'hFFC));
        vt.push_back(mk("LH FFE",     0, 3'b001, 32'hFFE, 12'h000, 0, 0, 2'b00, 3, 32'hFFC));
        vt.push_back(mk("LW wrap neg",0, 3'b010, 32'h10, 12'hFE0, 0, 0, 2'b10, 1, 0));
        vt.push_back(mk("LW wrap 0",  0, 3'b010, 32'hFFFFFFFF, 12'h001, 0, 0, 2'b00, 3, 32'h0));
        vt.push_back(mk("LB FFFFFFFF",0, 3'b000, 32'hFFFFFFFF, 12'h000, 0, 0, 2'b10, 1, 0));
        vt.push_back(mk("funct 011",  0, 3'b011, 32'h100, 12'h000, 0, 0, 2'b11, 1, 0));
        vt.push_back(mk("SBU",        1, 3'b100, 32'h100, 12'h000, 0, 0, 2'b11, 1, 0));
        vt.push_back(mk("funct 111",  0, 3'b111, 32'h101, 12'h000, 0, 0, 2'b11, 1, 0));
        vt.push_back(mk("SW 1000",    1, 3'b010, 32'h1000, 12'h000, 32'h1, 0, 2'b10, 1, 0));
        vt.push_back(mk("SW FFC",     1, 3'b010, 32'hFFC, 12'h000, 32'h11223344, 0, 2'b00, 2, 32'hFFC));
        vt.push_back(mk("LW FFC",     0, 3'b010, 32'hFFC, 12'h000, 0, 32'h11223344, 2'b00, 3, 32'hFFC));

        rst_n = 1'b0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct = 3'd0; bus.req_base = 32'd0;
        bus.req_imm = 12'd0; bus.req_wdata = 32'd0; bus.req_rd = 5'd0;
        bus.rsp_ready = 1'b1;
        repeat (3) tick();
        chk_reset_outs("reset");
        rst_n = 1'b1;
        #1;
        chk("ready after reset", 32'(bus.req_ready), 32'd1);

        for (int i = 0; i < vt.size(); i++)
            run_req(vt[i], 5'(i + 3));

        // Backpressure: response held while rsp_ready is low.
        bus.rsp_ready = 1'b0;
        drive_req(1'b0, 3'b010, 32'h100, 12'h000, 32'd0, 5'd9);
        guard = 0;
        do begin tick(); bus.req_valid = 1'b0; guard++; end while (!bus.rsp_valid && guard < 10);
        chk("bp rsp_valid", 32'(bus.rsp_valid), 32'd1);
        snap_rdata = bus.rsp_rdata;
        snap_rd    = bus.rsp_rd;
        chk("bp rdata", snap_rdata, 32'h12345678);
        r0 = rd_cnt; w0 = wr_cnt;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("bp hold valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp hold rdata", bus.rsp_rdata,      32'h12345678);
            chk("bp hold rd",    32'(bus.rsp_rd),    32'd9);
            chk("bp hold err",   32'(bus.rsp_err),   32'd0);
            chk("bp req_ready",  32'(bus.req_ready), 32'd0);
        end
        chk("bp no strobes", 32'((rd_cnt - r0) + (wr_cnt - w0)), 32'd0);
        // Release together with a waiting request: it must not be taken on the handshake edge.
        bus.rsp_ready = 1'b1;
        drive_req(1'b0, 3'b100, 32'h200, 12'h003, 32'd0, 5'd11);
        tick();
        chk("bp release valid", 32'(bus.rsp_valid), 32'd0);
        chk("bp release ready", 32'(bus.req_ready), 32'd1);
        tick();
        bus.req_valid = 1'b0;
        chk("bp next accepted", 32'(bus.req_ready), 32'd0);
        guard = 0;
        while (!bus.rsp_valid && guard < 10) begin tick(); guard++; end
        chk("bp next rdata", bus.rsp_rdata,   32'h00000080);
        chk("bp next rd",    32'(bus.rsp_rd), 32'd11);
        tick();

        // Reset while a store sits in ISSUE.
        drive_req(1'b1, 3'b010, 32'h300, 12'h000, 32'hDEADBEEF, 5'd4);
        tick();
        bus.req_valid = 1'b0;
        chk("rst issue write", 32'(bus.mem_write), 32'd1);
        chk("rst issue addr",  bus.mem_addr,       32'h300);
        rst_n = 1'b0;
        #1;
        chk_reset_outs("mid reset");
        tick();
        tick();
        chk("rst mem untouched", {mem[12'h303], mem[12'h302], mem[12'h301], mem[12'h300]}, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("ready after mid reset", 32'(bus.req_ready), 32'd1);
        run_req(mk("post-rst LW 300", 0, 3'b010, 32'h300, 12'h000, 0, 32'h0, 2'b00, 3, 32'h300), 5'd21);
        run_req(mk("post-rst LW 100", 0, 3'b010, 32'h100, 12'h000, 0, 32'h12345678, 2'b00, 3, 32'h100), 5'd22);

        chk("never both strobes", 32'(both_cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
